// File: rtl/jif_bus_pkg.sv
// Shared phase encoding and frame constants for the JIF byte-serial bus target.
package jif_bus_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        P1   = 4'd1,
        P2   = 4'd2,
        P3   = 4'd3,
        P4   = 4'd4,
        P5   = 4'd5,
        P6   = 4'd6,
        P7   = 4'd7,
        P8   = 4'd8,
        P9   = 4'd9
    } phase_t;

    localparam int FRAME_LEN   = 10;
    localparam int PH_WFLAG    = 5;
    localparam int PH_RD_FIRST = 6;
    localparam int PH_RD_LAST  = 9;
    localparam int BYTE_W      = 8;
    localparam int WORD_LANES  = 4;

    // Address/wdata arrive LSB lane first; read data leaves MSB lane first.
    localparam int WR_FIRST_LANE = 0;
    localparam int RD_FIRST_LANE = WORD_LANES - 1;

    function automatic phase_t next_phase(input phase_t p);
        if (p == IDLE || p == P9) begin
            return IDLE;
        end
        return phase_t'(p + 4'd1);
    endfunction

endpackage

// File: rtl/jif_word_ram.sv
// DEPTH x 32 register-array RAM: synchronous write, combinational read.
module jif_word_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/jif_bus_target.sv
// Memory-side target for the byte-serial CPU handler bus: deserialises each
// 10-phase frame, commits writes to word RAM or streams a read word back.
module jif_bus_target
    import jif_bus_pkg::*;
#(
    parameter int          ADDR_BITS = 6,
    parameter logic [31:0] ERR_WORD  = 32'hFFFF_FFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync,
    input  logic [7:0] addr_in,
    input  logic [7:0] data_in,
    output logic [7:0] rd_byte,
    output logic       rd_oe,
    output logic       wr_pulse,
    output logic       rd_pulse,
    output logic       err,
    output logic       busy
);

    phase_t state_reg, state_next, cur_phase;
    logic   mid_sync;
    logic [1:0] lane;

    logic [31:0] addr_sr_reg, wdata_sr_reg, rdata_sr_reg;
    logic [7:0]  rd_byte_reg;
    logic        rd_oe_reg, wr_pulse_reg, rd_pulse_reg, err_reg;

    logic                 hit, is_write, ram_we;
    logic [ADDR_BITS-1:0] word_idx;
    logic [31:0]          ram_rdata, fetch_word;
    logic                 unused_addr_lsbs;

    // The cycle carrying sync is phase 1 itself, so the registered state
    // names the phase this cycle would be in absent a sync.
    always_comb begin
        mid_sync   = sync && (state_reg != IDLE) && (state_reg != P1);
        cur_phase  = sync ? P1 : state_reg;
        state_next = next_phase(cur_phase);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign lane       = cur_phase[1:0] - 2'd1;
    assign hit        = (addr_sr_reg[31:ADDR_BITS+2] == '0);
    assign word_idx   = addr_sr_reg[ADDR_BITS+1:2];
    assign is_write   = addr_in[0];
    assign ram_we     = !rst && (cur_phase == P5) && is_write && hit;
    assign fetch_word = hit ? ram_rdata : ERR_WORD;
    // Byte-offset bits never select anything in a word-wide RAM.
    assign unused_addr_lsbs = ^addr_sr_reg[1:0];

    always_ff @(posedge clk) begin
        if (cur_phase >= P1 && cur_phase <= P4) begin
            addr_sr_reg[BYTE_W*lane +: BYTE_W]  <= addr_in;
            wdata_sr_reg[BYTE_W*lane +: BYTE_W] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_sr_reg <= '0;
            rd_byte_reg  <= '0;
            rd_oe_reg    <= 1'b0;
            wr_pulse_reg <= 1'b0;
            rd_pulse_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            wr_pulse_reg <= 1'b0;
            rd_pulse_reg <= 1'b0;
            if (mid_sync) begin
                err_reg <= 1'b1;
            end
            case (cur_phase)
                P1: begin
                    rd_oe_reg   <= 1'b0;
                    rd_byte_reg <= '0;
                end
                P5: begin
                    if (is_write) begin
                        if (hit) begin
                            wr_pulse_reg <= 1'b1;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end else begin
                        rd_pulse_reg <= 1'b1;
                        rd_oe_reg    <= 1'b1;
                        rdata_sr_reg <= fetch_word;
                        rd_byte_reg  <= fetch_word[31:24];
                        if (!hit) begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                P6, P7, P8: begin
                    // Write frames leave the return path idle.
                    if (rd_oe_reg) begin
                        rd_byte_reg  <= rdata_sr_reg[23:16];
                        rdata_sr_reg <= {rdata_sr_reg[23:0], 8'h00};
                    end
                end
                P9: begin
                    rd_oe_reg   <= 1'b0;
                    rd_byte_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    jif_word_ram #(
        .DEPTH (2**ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (word_idx),
        .wdata (wdata_sr_reg),
        .raddr (word_idx),
        .rdata (ram_rdata)
    );

    // An aborting sync releases the read lane in the same cycle.
    assign rd_oe    = rd_oe_reg && !mid_sync;
    assign rd_byte  = rd_oe ? rd_byte_reg : 8'h00;
    assign wr_pulse = wr_pulse_reg;
    assign rd_pulse = rd_pulse_reg;
    assign err      = err_reg;
    assign busy     = (cur_phase != IDLE);

endmodule
